instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 8-bit CPU. Owns the program counter (PC) and issues byte reads to program memory.
- Captures the opcode byte into the instruction register, and optionally a following immediate byte.
- Presents both bytes to the control FSM, which consumes `instr` in its decode stage.
- The control FSM drives this block through `fetch_req`, `imm_req`, `jmp_en` and `halt`.

Parameters:
- ADDR_W, 8: PC and memory address width in bits.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 15: maximum cycles to wait for `mem_ready`. Used only with IFU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  one-cycle pulse requesting an opcode fetch at PC.
- imm_req  in  1  one-cycle pulse requesting an immediate-byte fetch at PC.
- jmp_en  in  1  load PC from `jmp_addr`.
- jmp_addr  in  ADDR_W  jump target.
- halt  in  1  stop fetching until reset.
- mem_addr  out  ADDR_W  memory address; always equals PC.
- mem_rd  out  1  read strobe; held high until `mem_ready`.
- mem_rdata  in  8  read data, valid when `mem_ready` is high.
- mem_ready  in  1  read-complete handshake.
- instr  out  8  instruction register.
- imm  out  8  immediate register.
- instr_valid  out  1  one-cycle pulse after `instr` updates.
- imm_valid  out  1  one-cycle pulse after `imm` updates.
- pc  out  ADDR_W  current PC.
- busy  out  1  high while in WAIT_OP or WAIT_IMM.
- halted  out  1  high in HALT.
- fetch_err  out  1  timeout flag; tied to 0 when IFU_TIMEOUT_EN is not defined.

Behaviour:
- Reset (async):
  - state=IDLE, pc=RESET_PC, instr=0x00, imm=0x00.
  - All 1-bit outputs 0.
  - Any pending jump is cleared.
  - Reset mid-access abandons the read immediately; `mem_rd` drops the same cycle.
- States: IDLE, WAIT_OP, WAIT_IMM, HALT.
- IDLE, evaluated in priority order:
  - `halt` → HALT.
  - Else `jmp_en` → pc<=jmp_addr next edge; stay IDLE.
  - Else `fetch_req` → WAIT_OP.
  - Else `imm_req` → WAIT_IMM.
  - `fetch_req` and `imm_req` together: opcode fetch wins; `imm_req` is dropped.
  - `jmp_en` with `fetch_req`: the jump is applied and the fetch request is dropped. The FSM must re-request.
- WAIT_OP / WAIT_IMM:
  - `mem_rd`=1 and `mem_addr`=pc for every cycle in the state.
  - Edge with `mem_ready`=1:
    - Register load: `mem_rdata` → instr (WAIT_OP) or → imm (WAIT_IMM).
    - PC update: pc<=pc+1, or pc<=pending jump target if one is set.
    - Next state: IDLE.
    - Valid pulse: `instr_valid` or `imm_valid` is 1 for exactly the cycle after that edge.
  - Minimum latency from request to valid is 2 cycles when `mem_ready` is already high.
  - `fetch_req`/`imm_req` while busy: ignored, not queued.
  - `jmp_en` while busy: `jmp_addr` latched as pending (last one wins) and applied at completion in place of the increment.
  - `halt` while busy: latched. The access completes and the valid pulse is still produced, then the state goes to HALT instead of IDLE.
- HALT:
  - All requests and jumps are ignored.
  - `mem_rd`=0, `halted`=1.
  - Exit only by `rst`.
- PC arithmetic: modulo 2^ADDR_W. pc=0xFF increments to 0x00 with no flag.
- Outputs are registered except `mem_rd`, `busy` and `halted`, which decode the state.

Optional Feature:
- Macro: IFU_TIMEOUT_EN.
- Defined:
  - A 4-bit-plus counter clears on entry to WAIT_OP/WAIT_IMM and counts each cycle without `mem_ready`.
  - When TIMEOUT cycles elapse without `mem_ready`, the access is aborted and `mem_rd` drops.
  - The target register is loaded with 0x00 (NOP), the PC still advances, and the normal valid pulse fires.
  - `fetch_err` is set sticky and cleared only by `rst`.
- Not defined: no counter; `fetch_err`=0; the block waits indefinitely for `mem_ready`.

Test Plan:
- Reset, then `fetch_req` with `mem_ready` held 1 and `mem_rdata`=0x91 → `mem_rd`=1 at `mem_addr` 0x00 for one cycle; instr=0x91, `instr_valid` pulse at request+2, pc=0x01.
- `fetch_req`, then `mem_ready` low for 3 cycles before the data 0x5A arrives → `mem_rd` held 4 cycles; a second `fetch_req` during the wait is ignored; exactly one `instr_valid`; pc increments by exactly 1.
- pc=0xFF, `imm_req` with data 0x3C → imm=0x3C, `imm_valid` pulse, pc wraps to 0x00, instr unchanged.
- `fetch_req`, then `jmp_en` with `jmp_addr`=0x40 during the wait, then completion → pc=0x40 (not pc+1); a simultaneous `fetch_req`+`imm_req` in IDLE fetches the opcode only.
- `halt` asserted during WAIT_OP → access completes with `instr_valid`, then `halted`=1; later `fetch_req`/`jmp_en` cause no `mem_rd`; `rst` mid-halt → IDLE, pc=RESET_PC.
- IFU_TIMEOUT_EN with TIMEOUT=15 and `mem_ready` stuck at 0 → abort after 15 cycles; instr=0x00, `instr_valid` pulse, `fetch_err`=1 until `rst`, pc advanced.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Program-memory read bus between the fetch unit and memory.
// master: mem_addr/mem_rd out, mem_rdata/mem_ready in; slave mirrors it.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns PC, reads opcode/immediate bytes over mem (master).
// Ports: clk, rst, fetch_req, imm_req, jmp_en, jmp_addr, halt, mem bus,
// instr, imm, instr_valid, imm_valid, pc, busy, halted, fetch_err.
// Define IFU_TIMEOUT_EN to abort reads after TIMEOUT idle cycles.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              imm_req,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  instr_fetch_unit_if.master mem,
  output logic [7:0]        instr,
  output logic [7:0]        imm,
  output logic              instr_valid,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE, WAIT_OP, WAIT_IMM, HALT
  } state_t;

  state_t            state;
  logic              jp_vld;
  logic [ADDR_W-1:0] jp_tgt;
  logic              hp;
  logic              done;
  logic [7:0]        ld_data;
  logic [ADDR_W-1:0] nxt_pc;

  if (TIMEOUT < 1 || ADDR_W < 1) begin : g_bad_cfg
    $error("instr_fetch_unit: bad parameters");
  end

  assign busy   = (state == WAIT_OP) || (state == WAIT_IMM);
  assign halted = (state == HALT);
  assign mem.mem_rd   = busy;
  assign mem.mem_addr = pc;

  // A jump arriving on the completion edge is newest, so it beats the
  // pending target.
  assign nxt_pc = jmp_en ? jmp_addr :
                  jp_vld ? jp_tgt : pc + 1'b1;

`ifdef IFU_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 15) ? 4 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          to_hit;

  assign to_hit  = busy && !mem.mem_ready &&
                   (cnt == CW'(TIMEOUT - 1));
  assign done    = mem.mem_ready || to_hit;
  // Aborted reads deliver a NOP.
  assign ld_data = mem.mem_ready ? mem.mem_rdata : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (!busy)
        cnt <= '0;
      else if (!mem.mem_ready)
        cnt <= cnt + 1'b1;
      if (to_hit)
        fetch_err <= 1'b1;
    end
  end
`else
  assign done      = mem.mem_ready;
  assign ld_data   = mem.mem_rdata;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 8'h00;
      imm         <= 8'h00;
      instr_valid <= 1'b0;
      imm_valid   <= 1'b0;
      jp_vld      <= 1'b0;
      jp_tgt      <= '0;
      hp          <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      imm_valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          jp_vld <= 1'b0;
          hp     <= 1'b0;
          if (halt)
            state <= HALT;
          else if (jmp_en)
            pc <= jmp_addr;
          else if (fetch_req)
            state <= WAIT_OP;
          else if (imm_req)
            state <= WAIT_IMM;
        end
        WAIT_OP, WAIT_IMM: begin
          if (jmp_en) begin
            jp_vld <= 1'b1;
            jp_tgt <= jmp_addr;
          end
          if (halt)
            hp <= 1'b1;
          if (done) begin
            if (state == WAIT_OP) begin
              instr       <= ld_data;
              instr_valid <= 1'b1;
            end else begin
              imm       <= ld_data;
              imm_valid <= 1'b1;
            end
            pc    <= nxt_pc;
            state <= (hp || halt) ? HALT : IDLE;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit.
// Expected bytes/PC are queued at request time and popped on valid.
module tb_instr_fetch_unit;

  typedef struct {
    logic       kind;
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       fetch_req;
  logic       imm_req;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic       halt;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       instr_valid;
  logic       imm_valid;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       fetch_err;

  int checks;
  int failures;
  int rd_cnt;
  int iv_cnt;
  int mv_cnt;
  exp_t sbq[$];

  instr_fetch_unit_if #(.ADDR_W(8)) mem_bus ();

  instr_fetch_unit #(
    .ADDR_W(8),
    .RESET_PC(8'h00),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .imm_req(imm_req),
    .jmp_en(jmp_en),
    .jmp_addr(jmp_addr),
    .halt(halt),
    .mem(mem_bus.master),
    .instr(instr),
    .imm(imm),
    .instr_valid(instr_valid),
    .imm_valid(imm_valid),
    .pc(pc),
    .busy(busy),
    .halted(halted),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (instr_valid || imm_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  task automatic push(input logic k, input logic [7:0] d,
                      input logic [7:0] p);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.pc   = p;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_bus.mem_rd) rd_cnt++;
      if (instr_valid) iv_cnt++;
      if (imm_valid) mv_cnt++;
      if (instr_valid || imm_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_extra", sbq.size(), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_kind", {instr_valid, imm_valid},
              e.kind ? 2'b01 : 2'b10);
          chk("sb_data", e.kind ? imm : instr, e.data);
          chk("sb_pc", pc, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    fetch_req = 0; imm_req = 0; jmp_en = 0;
    jmp_addr = 0; halt = 0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    rd_cnt = 0; iv_cnt = 0; mv_cnt = 0;
    @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_instr", instr, 8'h00);
    chk("rst_imm", imm, 8'h00);
    chk("rst_flags",
        {instr_valid, imm_valid, busy, halted, fetch_err}, 0);
    chk("rst_rd", mem_bus.mem_rd, 0);
    step();
    rst = 1'b0;

    // single fetch, memory ready immediately
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 8'h91;
    rd_cnt = 0;
    fetch_req = 1'b1;
    push(0, 8'h91, 8'h01);
    step();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("t1_rd", mem_bus.mem_rd, 1);
    chk("t1_addr", mem_bus.mem_addr, 8'h00);
    chk("t1_early", instr_valid, 0);
    step();
    @(negedge clk);
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 8'h91);
    step();
    @(negedge clk);
    chk("t1_pulse", instr_valid, 0);
    chk("t1_rdcnt", rd_cnt, 1);

    // wait states with an ignored second request
    step();
    rd_cnt = 0; iv_cnt = 0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 8'h5A;
    fetch_req = 1'b1;
    push(0, 8'h5A, 8'h02);
    step();
    fetch_req = 1'b0;
    step();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    mem_bus.mem_ready = 1'b1;
    step();
    repeat (3) step();
    chk("t2_rdcnt", rd_cnt, 4);
    chk("t2_ivcnt", iv_cnt, 1);
    chk("t2_pc", pc, 8'h02);

    // PC wrap on immediate fetch
    jmp_en = 1'b1;
    jmp_addr = 8'hFF;
    step();
    jmp_en = 1'b0;
    chk("t3_jmp", pc, 8'hFF);
    mv_cnt = 0;
    mem_bus.mem_rdata = 8'h3C;
    imm_req = 1'b1;
    push(1, 8'h3C, 8'h00);
    step();
    imm_req = 1'b0;
    wait_valid("t3_wait", 5);
    chk("t3_imm", imm, 8'h3C);
    chk("t3_instr", instr, 8'h5A);
    chk("t3_pc", pc, 8'h00);
    step();

    // jump during wait replaces increment
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 8'h77;
    fetch_req = 1'b1;
    push(0, 8'h77, 8'h40);
    step();
    fetch_req = 1'b0;
    jmp_en = 1'b1;
    jmp_addr = 8'h40;
    step();
    jmp_en = 1'b0;
    mem_bus.mem_ready = 1'b1;
    wait_valid("t4_wait", 5);
    chk("t4_pc", pc, 8'h40);
    step();

    // fetch_req + imm_req together: opcode only
    iv_cnt = 0; mv_cnt = 0;
    mem_bus.mem_rdata = 8'h12;
    fetch_req = 1'b1;
    imm_req = 1'b1;
    push(0, 8'h12, 8'h41);
    step();
    fetch_req = 1'b0;
    imm_req = 1'b0;
    wait_valid("t4b_wait", 5);
    repeat (3) step();
    chk("t4b_iv", iv_cnt, 1);
    chk("t4b_mv", mv_cnt, 0);
    chk("t4b_imm", imm, 8'h3C);

    // halt during WAIT_OP
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 8'hA5;
    fetch_req = 1'b1;
    push(0, 8'hA5, 8'h42);
    step();
    fetch_req = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    mem_bus.mem_ready = 1'b1;
    wait_valid("t5_wait", 5);
    chk("t5_halted", halted, 1);
    step();
    rd_cnt = 0;
    fetch_req = 1'b1;
    imm_req = 1'b1;
    jmp_en = 1'b1;
    jmp_addr = 8'h10;
    repeat (4) step();
    fetch_req = 0; imm_req = 0; jmp_en = 0;
    chk("t5_rdcnt", rd_cnt, 0);
    chk("t5_pc", pc, 8'h42);
    chk("t5_stay", {halted, busy}, 2'b10);
    rst = 1'b1;
    #2;
    chk("t5_rst_pc", pc, 8'h00);
    chk("t5_rst_st", {halted, busy}, 2'b00);
    step();
    rst = 1'b0;

    // reset mid-access drops mem_rd and the pending jump
    mem_bus.mem_ready = 1'b0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    jmp_en = 1'b1;
    jmp_addr = 8'h80;
    step();
    jmp_en = 1'b0;
    chk("t6_rd_on", mem_bus.mem_rd, 1);
    rst = 1'b1;
    #1;
    chk("t6_rd_off", mem_bus.mem_rd, 0);
    step();
    rst = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 8'hEE;
    fetch_req = 1'b1;
    push(0, 8'hEE, 8'h01);
    step();
    fetch_req = 1'b0;
    wait_valid("t6_wait", 5);
    step();

`ifdef IFU_TIMEOUT_EN
    // memory never answers
    rd_cnt = 0;
    mem_bus.mem_ready = 1'b0;
    fetch_req = 1'b1;
    push(0, 8'h00, 8'h02);
    step();
    fetch_req = 1'b0;
    wait_valid("t7_wait", 40);
    chk("t7_instr", instr, 8'h00);
    chk("t7_err", fetch_err, 1);
    step();
    repeat (3) step();
    chk("t7_rdcnt", rd_cnt, 15);
    chk("t7_sticky", fetch_err, 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_err", fetch_err, 0);
    step();
    rst = 1'b0;
`else
    chk("no_err", fetch_err, 0);
`endif

    step();
    chk("sb_left", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
